// File: rtl/minifloat_frame_accumulator.sv
// minifloat_frame_accumulator
// Decodes a stream of (M,E) minifloat beats back to integers (M << E) and
// accumulates a saturating per-frame sum and beat count. One result per frame
// is presented on a valid/ready output and held stable until it is taken.
// Pipeline: stage 1 decode register, stage 2 accumulator, 3-state frame FSM.
// Optional build macro: MINIFLOAT_ACC_MAX_TRACK_EN adds a largest-beat tracker
// driving out_max. Without it, out_max is tied to zero.
module minifloat_frame_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_m,
    input  logic [2:0]       in_e,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic [10:0]      out_max
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               accept;
    logic [10:0]        beat_val;

    logic               d_vld;
    logic               d_last;
    logic [10:0]        d_val;

    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               sat;
    logic [ACC_W:0]     sum_ext;
    logic               acc_en;
    logic               clear;

    assign accept   = in_valid & in_ready;
    assign beat_val = {7'd0, in_m} << in_e;

    // Stage 1: capture the decoded beat; valid bit follows acceptance every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_vld  <= 1'b0;
            d_val  <= '0;
            d_last <= 1'b0;
        end else begin
            d_vld <= accept;
            if (accept) begin
                d_val  <= beat_val;
                d_last <= in_last;
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        clear     = 1'b0;
        // Blocking input once the last beat sits in stage 1 keeps the next
        // frame's first beat out of the accumulator until the result is taken.
        in_ready  = (state != HOLD) & ~(d_vld & d_last);
        case (state)
            IDLE: begin
                if (d_vld) begin
                    state_nxt = d_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (d_vld && d_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign acc_en  = d_vld & (state != HOLD);
    assign sum_ext = {1'b0, acc} + {{(ACC_W - 10){1'b0}}, d_val};

    // Stage 2: saturating sum, sticky overflow flag and saturating beat count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (acc_en) begin
            acc <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            sat <= sat | sum_ext[ACC_W];
            if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_sat   = sat;

`ifdef MINIFLOAT_ACC_MAX_TRACK_EN
    logic [10:0] max_q;

    // Largest decoded beat of the current frame, cleared with the accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
        end else if (clear) begin
            max_q <= '0;
        end else if (acc_en && (d_val > max_q)) begin
            max_q <= d_val;
        end
    end

    assign out_max = max_q;
`else
    assign out_max = '0;
`endif

endmodule

// File: tb/tb_minifloat_frame_accumulator.sv
// Scoreboard bench for minifloat_frame_accumulator: the driver pushes the
// expected frame result (computed arithmetically from the beats) when a last
// beat is accepted; an independent monitor compares whenever out_valid is up.
module tb_minifloat_frame_accumulator;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;
    localparam longint MAXS = (64'd1 << ACC_W) - 1;
    localparam int     MAXC = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_m = '0;
    logic [2:0]       in_e = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;
    logic [10:0]      out_max;

    minifloat_frame_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_m(in_m), .in_e(in_e), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count),
        .out_sat(out_sat), .out_max(out_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        int     count;
        int     sat;
        int     max;
        int     vcyc;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low

    longint f_total = 0;
    int     f_n = 0;
    int     f_max = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer ready driver
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compare presented results against the scoreboard head
    logic prev_valid = 1'b0;
    logic after_hs = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            after_hs   = 1'b0;
        end else begin
            if (after_hs) begin
                chk("in_ready_after_handshake", longint'(in_ready), 1);
                chk("out_valid_after_handshake", longint'(out_valid), 0);
                after_hs = 1'b0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    if (!prev_valid) chk("latency", cyc, q[0].vcyc);
                    chk("out_sum", longint'(out_sum), q[0].sum);
                    chk("out_count", longint'(out_count), q[0].count);
                    chk("out_sat", longint'(out_sat), q[0].sat);
                    chk("out_max", longint'(out_max), q[0].max);
                    chk("in_ready_in_hold", longint'(in_ready), 0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        after_hs = 1'b1;
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    // Entry/exit point: 1 time unit after a rising edge
    task automatic send_beat(input logic [3:0] m, input logic [2:0] e,
                             input logic last, input int gap);
        logic took;
        int   v;
        exp_t x;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_m     = m;
        in_e     = e;
        in_last  = last;
        took     = 1'b0;
        for (int w = 0; w < 400 && !took; w++) begin
            @(negedge clk);
            took = in_ready;
            if (took) begin
                v = int'(m) * (1 << int'(e));
                f_total += v;
                f_n++;
                if (v > f_max) f_max = v;
                if (last) begin
                    x.sum   = (f_total > MAXS) ? MAXS : f_total;
                    x.count = (f_n > MAXC) ? MAXC : f_n;
                    x.sat   = (f_total > MAXS) ? 1 : 0;
`ifdef MINIFLOAT_ACC_MAX_TRACK_EN
                    x.max   = f_max;
`else
                    x.max   = 0;
`endif
                    x.vcyc  = cyc + 2;
                    q.push_back(x);
                    f_total = 0;
                    f_n     = 0;
                    f_max   = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        if (!took) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (q.size() != 0) chk("drain_timeout", longint'(q.size()), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, longint'(in_ready), 1);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_out_sum"}, longint'(out_sum), 0);
        chk({tag, "_out_count"}, longint'(out_count), 0);
        chk({tag, "_out_sat"}, longint'(out_sat), 0);
        chk({tag, "_out_max"}, longint'(out_max), 0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-beat frame: 40 + 1920
        send_beat(4'd5, 3'd3, 1'b0, 0);
        send_beat(4'd15, 3'd7, 1'b1, 0);
        drain();

        // Single zero-valued beat
        send_beat(4'd0, 3'd0, 1'b1, 0);
        drain();

        // Result held with ready low while the next beat waits
        rdy_mode = 2;
        send_beat(4'd3, 3'd2, 1'b0, 0);
        send_beat(4'd7, 3'd1, 1'b1, 0);
        in_valid = 1'b1;
        in_m     = 4'd9;
        in_e     = 3'd4;
        in_last  = 1'b1;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("hold_reached", longint'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready_low", longint'(in_ready), 0);
            chk("hold_out_valid_high", longint'(out_valid), 1);
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_beat(4'd9, 3'd4, 1'b1, 0);
        drain();

        // Sum saturation: 40 x 1920 exceeds 2^16-1
        for (int i = 0; i < 40; i++) send_beat(4'd15, 3'd7, 1'(i == 39), 0);
        drain();

        // Count saturation without sum overflow
        for (int i = 0; i < 300; i++) send_beat(4'd1, 3'd0, 1'(i == 299), 0);
        drain();

        // Randomized frames with random gaps and consumer backpressure
        rdy_mode = 1;
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                send_beat(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                          1'(b == len - 1), $urandom_range(0, 2));
            end
        end
        drain();
        rdy_mode = 0;

        // Reset mid-frame discards partial state
        for (int i = 0; i < 3; i++) send_beat(4'd6, 3'd5, 1'b0, 0);
        rst = 1'b1;
        f_total = 0;
        f_n     = 0;
        f_max   = 0;
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_beat(4'd2, 3'd1, 1'b1, 0);
        drain();

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/minifloat_frame_accumulator.md
Name: minifloat_frame_accumulator

Overview:
- Downstream consumer of the integer-to-minifloat converter output: 4-bit mantissa M and 3-bit exponent E.
- Accepts a valid/ready stream of (M,E) beats grouped into frames by a last flag.
- Decodes each beat back to an integer, accumulates the frame sum with saturation, and presents one result per frame on a valid/ready output.
- Two-stage pipeline (decode, accumulate) plus a 3-state frame FSM.

Parameters:
- ACC_W, 16, accumulator and out_sum width; legal range 11..32.
- CNT_W, 8, beat-counter and out_count width; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  beat present
- in_ready  output  1  block accepts beat this cycle
- in_m  input  4  mantissa M
- in_e  input  3  exponent E
- in_last  input  1  final beat of frame
- out_valid  output  1  frame result present
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_W  saturated frame sum
- out_count  output  CNT_W  beats in frame (saturating)
- out_sat  output  1  sum saturated during frame
- out_max  output  11  largest decoded beat (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high on rst, single clock clk.
- Reset values:
  - in_ready=1, out_valid=0, out_sum=0, out_count=0, out_sat=0, out_max=0.
  - State=IDLE; pipeline valid bits cleared.
- Decoding: value = M << E, 11-bit unsigned, range 0..1920, zero-extended to ACC_W.
- Accept: a beat is accepted when in_valid & in_ready.
- Stage 1 (decode) registers d_vld, d_val[10:0] and d_last on every cycle:
  - d_vld = accept.
  - d_val and d_last are loaded only on accept.
- in_ready = (state != HOLD) & ~(d_vld & d_last). This stops acceptance the cycle after a last beat is taken.
- Stage 2 (accumulate), when d_vld:
  - acc <= min(acc + d_val, 2^ACC_W-1).
  - sat <= sat | overflow.
  - cnt <= min(cnt+1, 2^CNT_W-1).
- FSM:
  - IDLE: acc=cnt=sat=0. On d_vld go to ACC, or to HOLD if d_last.
  - ACC: on d_vld & d_last go to HOLD.
  - HOLD: out_valid=1, outputs stable, no accumulation. On out_valid & out_ready, clear acc/cnt/sat/max and go to IDLE; in_ready=1 the following cycle.
- Outputs out_sum/out_count/out_sat/out_max are driven directly from the accumulator registers. They are held constant while out_valid=1.
- Latency: last beat accepted at cycle t gives out_valid=1 at t+2.
- Throughput: one beat per cycle within a frame. Frame gap is at least 3 cycles (last accept, HOLD, handshake).
- Single-beat frame (first beat has in_last=1) is legal and yields count 1.
- Zero-valued beats (M=0) count toward out_count.
- out_valid must not drop without out_ready. in_ready is independent of in_valid (no combinational path from in_valid to in_ready).
- Count saturation does not set out_sat. out_sat reflects sum overflow only.
- rst asserted mid-frame or in HOLD discards all partial state immediately, with no output produced.

Optional Feature:
- Macro MINIFLOAT_ACC_MAX_TRACK_EN.
- Defined: an 11-bit max register updates to max(max, d_val) on each stage-2 beat, is cleared with the accumulator, and drives out_max.
- Undefined: no max register; out_max tied to 0. The port is present in both builds.

Test Plan:
- Frame (M=5,E=3),(M=15,E=7,last), out_ready=1 -> out_sum=1960, out_count=2, out_sat=0, out_valid 2 cycles after last accept; out_max=1920 with macro, 0 without.
- Single beat (M=0,E=0,last) -> out_sum=0, out_count=1, out_sat=0.
- ACC_W=11, frame (15,7),(15,7,last) -> out_sum=2047, out_sat=1, out_count=2.
- Result pending with out_ready=0 for 5 cycles, in_valid=1 throughout -> in_ready=0, outputs unchanged. Then out_ready=1 for one cycle -> next cycle in_ready=1 and the next frame starts from acc=0.
- CNT_W=2, five-beat frame of (1,0) -> out_count=3, out_sum=5, out_sat=0.
- rst pulsed after 3 beats of a frame -> all outputs return to reset values. A following frame (2,1,last) yields out_sum=4, out_count=1.
